// File: rtl/btn_debounce_press.sv
// Push-button conditioner: 2-flop sync, polarity fix, debounce, press classifier.
// Latency: level/press/release DEBOUNCE_CYCLES+1 edges after sync1 sees a steady value; no backpressure.
module btn_debounce_press #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic short_click,
  output logic long_press
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic              RELEASED  = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

  logic              sync1, sync2;
  logic              p_sync;
  logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
  logic              db_flip, level_rise, level_fall;
  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              press_nxt, release_nxt, short_nxt, long_nxt;

  // Reset loads the released value so leaving reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign p_sync     = sync2 ^ BTN_ACTIVE_LOW;
  assign db_flip    = (p_sync != btn_level) && (db_cnt == DB_LAST);
  assign level_rise = db_flip & ~btn_level;
  assign level_fall = db_flip &  btn_level;

  always_comb begin
    db_cnt_nxt = '0;
    if (p_sync != btn_level && !db_flip)
      db_cnt_nxt = db_cnt + DB_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      db_cnt    <= db_cnt_nxt;
      btn_level <= btn_level ^ db_flip;
    end
  end

  // Classifier reacts to the flip decision so pulses land on the same edge as the level change.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (level_rise) begin
          press_nxt = 1'b1;
          hold_nxt  = '0;
          state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        hold_nxt = hold_cnt + HOLD_ONE;
        if (level_fall) begin
          release_nxt = 1'b1;
          short_nxt   = 1'b1;
          state_nxt   = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (level_fall) begin
          release_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      short_click <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      short_click <= short_nxt;
      long_press  <= long_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce_press.sv
// Directed bench for btn_debounce_press with DEBOUNCE_CYCLES=8, LONG_CYCLES=40, active-low pad.
module tb_btn_debounce_press;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level, btn_press, btn_release, short_click, long_press;

  int checks = 0;
  int errors = 0;

  btn_debounce_press #(
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (40),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .short_click(short_click),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  // One segment: drive btn for n edges. Edges 1..n-1 expect {lvl_pre,0000};
  // edge n expects fin = {level, press, release, short_click, long_press}.
  typedef struct {
    logic       btn;
    int         n;
    logic       lvl_pre;
    logic [4:0] fin;
  } seg_t;

  seg_t tbl[16];

  task automatic check(input int id, input int cyc, input logic [4:0] exp);
    logic [4:0] act;
    act = {btn_level, btn_press, btn_release, short_click, long_press};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL seg%0d cyc%0d: {lvl,press,rel,short,long}=%b expected %b",
               id, cyc, act, exp);
    end
  endtask

  task automatic run_seg(input int id, input logic b, input int n,
                         input logic lvl_pre, input logic [4:0] fin);
    btn_in = b;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      check(id, i, (i == n) ? fin : {lvl_pre, 4'b0000});
    end
  endtask

  initial begin
    // idle, clean press, short hold, short release
    tbl[0]  = '{1'b1, 50, 1'b0, 5'b00000};
    tbl[1]  = '{1'b0, 10, 1'b0, 5'b11000};
    tbl[2]  = '{1'b0, 15, 1'b1, 5'b10000};
    tbl[3]  = '{1'b1, 10, 1'b1, 5'b00110};
    tbl[4]  = '{1'b1,  5, 1'b0, 5'b00000};
    // bounce: 5 low, 1 high glitch, then steady low
    tbl[5]  = '{1'b0,  5, 1'b0, 5'b00000};
    tbl[6]  = '{1'b1,  1, 1'b0, 5'b00000};
    tbl[7]  = '{1'b0, 10, 1'b0, 5'b11000};
    // long press exactly 40 edges after btn_press, then release without short_click
    tbl[8]  = '{1'b0, 40, 1'b1, 5'b10001};
    tbl[9]  = '{1'b0, 10, 1'b1, 5'b10000};
    tbl[10] = '{1'b1, 10, 1'b1, 5'b00100};
    tbl[11] = '{1'b1,  5, 1'b0, 5'b00000};
    // release lands on press+40, the long threshold edge: release wins
    tbl[12] = '{1'b0, 10, 1'b0, 5'b11000};
    tbl[13] = '{1'b0, 30, 1'b1, 5'b10000};
    tbl[14] = '{1'b1, 10, 1'b1, 5'b00110};
    tbl[15] = '{1'b1,  5, 1'b0, 5'b00000};

    rst    = 1'b1;
    btn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check(100, i, 5'b00000);
    end
    rst = 1'b0;

    for (int s = 0; s < 16; s++)
      run_seg(s, tbl[s].btn, tbl[s].n, tbl[s].lvl_pre, tbl[s].fin);

    // Toggling every cycle never survives the debounce window.
    for (int k = 0; k < 20; k++)
      run_seg(200 + k, (k % 2 == 1), 1, 1'b0, 5'b00000);
    run_seg(220, 1'b1, 12, 1'b0, 5'b00000);

    // Reset 20 cycles into a press with the button still held.
    run_seg(300, 1'b0, 10, 1'b0, 5'b11000);
    run_seg(301, 1'b0, 10, 1'b1, 5'b10000);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check(302, i, 5'b00000);
    end
    rst = 1'b0;
    run_seg(303, 1'b0, 10, 1'b0, 5'b11000);
    run_seg(304, 1'b0, 40, 1'b1, 5'b10001);
    run_seg(305, 1'b1, 10, 1'b1, 5'b00100);
    run_seg(306, 1'b1,  5, 1'b0, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
